// File: rtl/fib_check_pkg.sv
// fib_check_pkg: shared state encoding, seed constant and address helper for the Fibonacci result checker
package fib_check_pkg;
    typedef enum logic [1:0] {
        WATCH = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

    localparam logic [31:0] FIB_SEED        = 32'd1;
    localparam logic [31:0] DEFAULT_HALT_PC = 32'd100;

    function automatic logic [31:0] word_addr(input logic [7:0] idx);
        return {22'd0, idx, 2'b00};
    endfunction
endpackage

// File: rtl/fib_result_checker_fib_seq_gen.sv
// fib_seq_gen: produces the expected Fibonacci term for the current scan step (two seeds, then a+b)
module fib_seq_gen
    import fib_check_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    output logic [31:0] term
);
    logic [31:0] a, b;
    logic [1:0]  n;

    assign term = (n < 2'd2) ? FIB_SEED : a + b;

    // emit the two seeds first, then slide the a/b window once per generated sum
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            a <= FIB_SEED;
            b <= FIB_SEED;
            n <= 2'd0;
        end else if (step) begin
            n <= (n < 2'd2) ? n + 2'd1 : n;
            a <= (n < 2'd2) ? a : b;
            b <= (n < 2'd2) ? b : term;
        end
    end
endmodule

// File: rtl/fib_result_checker.sv
// fib_result_checker: waits for the CPU to park at HALT_PC, then verifies data memory holds the Fibonacci sequence.
// Optional first-mismatch capture is built when FIB_CHECK_FIRST_ERR_EN is defined.
module fib_result_checker
    import fib_check_pkg::*;
#(
    parameter logic [31:0] HALT_PC        = DEFAULT_HALT_PC,
    parameter int          STABLE_CYCLES  = 10,
    parameter int          NUM_TERMS      = 10,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] scan_addr,
    input  logic [31:0] scan_rdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  err_count,
    output logic [7:0]  first_err_idx,
    output logic [31:0] first_err_data
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    chk_state_t    state, state_nxt;
    logic [31:0]   prev_pc;
    logic [SW-1:0] stable, stable_nxt;
    logic [CW-1:0] cyc, cyc_nxt;
    logic [7:0]    idx;
    logic [31:0]   exp_term;
    logic          halt_hit, time_hit, last, mismatch;

    assign stable_nxt = (pc == HALT_PC && pc == prev_pc) ? stable + SW'(1) : '0;
    assign cyc_nxt    = cyc + CW'(1);
    assign halt_hit   = stable_nxt == SW'(STABLE_CYCLES);
    assign time_hit   = cyc_nxt == CW'(TIMEOUT_CYCLES);
    assign last       = idx == 8'(NUM_TERMS - 1);
    assign mismatch   = busy && scan_rdata != exp_term;
    assign scan_addr  = word_addr(idx);
    assign pass       = done && err_count == 8'd0 && !timeout;

    fib_seq_gen u_gen (
        .clk   (clk),
        .reset (reset),
        .clear (state == WATCH),
        .step  (busy),
        .term  (exp_term)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? WATCH : state_nxt;
    end

    // next state and status; a halt seen in the same cycle as the timeout still starts the scan
    always_comb begin
        state_nxt = state;
        busy      = state == SCAN;
        done      = state == DONE;
        state_nxt = (state == WATCH) ? (halt_hit ? SCAN : (time_hit ? DONE : WATCH))
                  : (busy && last)   ? DONE : state;
    end

    // watch-phase counters and sticky timeout flag; frozen once the watch phase ends
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc <= '0;
            stable  <= '0;
            cyc     <= '0;
            timeout <= 1'b0;
        end else if (state == WATCH) begin
            prev_pc <= pc;
            stable  <= stable_nxt;
            cyc     <= cyc_nxt;
            timeout <= time_hit && !halt_hit;
        end
    end

    // scan index and saturating mismatch counter
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            err_count <= '0;
        end else begin
            idx       <= (busy && !last) ? idx + 8'd1 : idx;
            err_count <= err_count + 8'(mismatch && err_count != 8'hFF);
        end
    end

`ifdef FIB_CHECK_FIRST_ERR_EN
    // capture location and data of the first mismatching word
    always_ff @(posedge clk) begin
        if (reset) begin
            first_err_idx  <= '0;
            first_err_data <= '0;
        end else if (mismatch && err_count == 8'd0) begin
            first_err_idx  <= idx;
            first_err_data <= scan_rdata;
        end
    end
`else
    assign first_err_idx  = '0;
    assign first_err_data = '0;
`endif
endmodule

// File: tb/tb_fib_result_checker.sv
// tb_fib_result_checker: scoreboard bench with a trace-based reference model for fib_result_checker
module tb_fib_result_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] scan_addr, scan_rdata, first_err_data;
    logic        busy, done, pass, timeout;
    logic [7:0]  err_count, first_err_idx;

    typedef struct {
        int          done_cyc;
        int          busy_start;
        int          busy_len;
        bit          pass;
        bit          tmo;
        int          err;
        int          fidx;
        logic [31:0] fdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          n_cmp = 0, n_bad = 0, ndone = 0, tcyc = 0;
    int          bstart = -1, blen = 0;
    bit          pdone = 1'b0;
    logic [31:0] mem[16];
    int unsigned trace[$];

    always #5 clk = ~clk;

    fib_result_checker dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .scan_addr      (scan_addr),
        .scan_rdata     (scan_rdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_count      (err_count),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data)
    );

    assign scan_rdata = (scan_addr < 32'd64) ? mem[scan_addr[5:2]] : 32'd0;

    always @(posedge clk) tcyc <= reset ? 0 : tcyc + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, expv, tcyc);
        end
    endtask

    function automatic int unsigned pc_at(input int c);
        return (c < trace.size()) ? trace[c] : trace[trace.size() - 1];
    endfunction

    function automatic exp_t model();
        exp_t        e;
        int          run = 0;
        int          ch = -1;
        logic [31:0] f[10];
        for (int c = 0; c < 1000 && ch < 0; c++) begin
            run = (pc_at(c) == 100) ? run + 1 : 0;
            if (run >= 11) ch = c;
        end
        e.err = 0; e.fidx = 0; e.fdata = 0;
        if (ch < 0) begin
            e.done_cyc = 1000; e.busy_start = -1; e.busy_len = 0; e.tmo = 1; e.pass = 0;
        end else begin
            e.done_cyc = ch + 11; e.busy_start = ch + 1; e.busy_len = 10; e.tmo = 0;
            for (int i = 0; i < 10; i++) begin
                f[i] = (i < 2) ? 32'd1 : f[i-1] + f[i-2];
                if (mem[i] != f[i]) begin
                    if (e.err == 0) begin e.fidx = i; e.fdata = mem[i]; end
                    e.err++;
                end
            end
            e.pass = (e.err == 0);
        end
        return e;
    endfunction

    // monitor: tracks the scan window and checks results whenever done rises
    always @(negedge clk) begin
        if (tcyc == 0) begin bstart = -1; blen = 0; end
        if (busy) begin
            if (bstart < 0) bstart = tcyc;
            chk("scan_addr", scan_addr, 4 * (tcyc - bstart));
            blen++;
        end
        if (done && !pdone) begin
            if (sb.size() == 0) chk("unexpected_done", done, 0);
            else begin
                me = sb.pop_front();
                chk("done_cycle", tcyc, me.done_cyc);
                chk("busy_start", bstart, me.busy_start);
                chk("busy_len", blen, me.busy_len);
                chk("pass", pass, me.pass);
                chk("timeout", timeout, me.tmo);
                chk("err_count", err_count, me.err);
`ifdef FIB_CHECK_FIRST_ERR_EN
                chk("first_err_idx", first_err_idx, me.fidx);
                chk("first_err_data", first_err_data, me.fdata);
`else
                chk("first_err_idx", first_err_idx, 0);
                chk("first_err_data", first_err_data, 0);
`endif
            end
            ndone++;
        end
        pdone = done;
    end

    task automatic set_fib();
        for (int i = 0; i < 16; i++) mem[i] = (i < 2) ? 32'd1 : ((i < 10) ? mem[i-1] + mem[i-2] : 32'd0);
    endtask

    task automatic walk();
        trace.delete();
        for (int k = 0; k < 25; k++) trace.push_back(4 * k);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_case();
        exp_t e;
        int   n0;
        e = model();
        sb.push_back(e);
        do_reset();
        n0 = ndone;
        for (int k = 0; k < 3000 && ndone == n0; k++) begin
            pc = pc_at(tcyc);
            @(negedge clk);
        end
        chk("done_seen", ndone - n0, 1);
        for (int k = 0; k < 4; k++) begin
            pc = $urandom;
            @(negedge clk);
        end
        chk("sticky_done", done, 1);
        chk("sticky_busy", busy, 0);
        chk("sticky_err", err_count, e.err);
        chk("sticky_pass", pass, e.pass);
    endtask

    task automatic run_abort();
        int k = 0;
        do_reset();
        while (!(busy && scan_addr == 32'd16) && k < 3000) begin
            pc = pc_at(tcyc);
            @(negedge clk);
            k++;
        end
        chk("abort_reached", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_count, 0);
        chk("abort_addr", scan_addr, 0);
    endtask

    initial begin
        set_fib();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err", err_count, 0);
        chk("rst_addr", scan_addr, 0);
        chk("rst_fidx", first_err_idx, 0);
        chk("rst_fdata", first_err_data, 0);

        walk(); trace.push_back(100);
        run_case();

        mem[6] = 32'd14;
        run_case();

        set_fib();
        trace.delete();
        for (int k = 0; k < 1100; k++) trace.push_back((k % 2) ? 100 : 96);
        run_case();

        walk();
        repeat (9) trace.push_back(100);
        trace.push_back(104);
        trace.push_back(100);
        run_case();

        walk(); trace.push_back(100);
        run_abort();
        run_case();

        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        run_case();

        for (int r = 0; r < 8; r++) begin
            trace.delete();
            repeat ($urandom_range(0, 30)) trace.push_back(4 * $urandom_range(0, 26));
            repeat ($urandom_range(0, 12)) trace.push_back(100);
            trace.push_back($urandom_range(0, 1) ? 104 : 96);
            trace.push_back(100);
            set_fib();
            for (int i = 0; i < 10; i++)
                if ($urandom_range(0, 3) == 0) mem[i] = $urandom_range(0, 3) ? $urandom : mem[i] + 32'd1;
            run_case();
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
